// File: rtl/cache_wb_buffer.sv
`timescale 1ns/1ps
// Victim buffer between the L2 D-cache memory port and the arbiter. Read misses bypass queued evictions.
// Optional macro WBUF_READ_FWD_EN: reads that hit a buffered line are answered from the buffer.
module cache_wb_buffer #(
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [31:0]  mem_address,
    input  logic         mem_read,
    input  logic         mem_write,
    input  logic [255:0] mem_wdata,
    output logic [255:0] mem_rdata,
    output logic         mem_resp,
    output logic [31:0]  pmem_address,
    output logic         pmem_read,
    output logic         pmem_write,
    output logic [255:0] pmem_wdata,
    input  logic [255:0] pmem_rdata,
    input  logic         pmem_resp,
    output logic         wb_empty
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef enum logic [1:0] {IDLE, RESP, READ_MISS, DRAIN} state_t;

    state_t        state, state_next;
    logic [26:0]   tags  [DEPTH];
    logic [255:0]  lines [DEPTH];
    logic [PW-1:0] head, tail;
    logic [CW-1:0] count, count_next;
    logic [255:0]  rdata_q;
    logic [DEPTH-1:0] valid;
    logic          hit;
    logic [PW-1:0] hit_idx;
    logic          unused_addr_bits;

    assign unused_addr_bits = ^mem_address[4:0];

    // An entry is live when its distance from head is below the occupancy.
    for (genvar g = 0; g < DEPTH; g++) begin : g_valid
        logic [PW-1:0] off;
        assign off      = PW'(g) - head;
        assign valid[g] = ({1'b0, off} < count);
    end

    // Coalescing keeps tags unique, so at most one entry can match.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid[i] && tags[i] == mem_address[31:5]) begin
                hit     = 1'b1;
                hit_idx = PW'(i);
            end
        end
    end

    always_comb begin
        state_next   = state;
        count_next   = count;
        mem_resp     = 1'b0;
        mem_rdata    = rdata_q;
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_address = '0;
        pmem_wdata   = '0;
        case (state)
            IDLE: begin
                if (mem_read) begin
`ifdef WBUF_READ_FWD_EN
                    state_next = hit ? RESP : READ_MISS;
`else
                    state_next = hit ? DRAIN : READ_MISS;
`endif
                end else if (mem_write) begin
                    if (hit) begin
                        state_next = RESP;
                    end else if (count != FULL) begin
                        state_next = RESP;
                        count_next = count + 1'b1;
                    end else begin
                        state_next = DRAIN;
                    end
                end else if (count != '0) begin
                    state_next = DRAIN;
                end
            end
            RESP: begin
                mem_resp   = 1'b1;
                state_next = IDLE;
            end
            READ_MISS: begin
                pmem_read    = 1'b1;
                pmem_address = {mem_address[31:5], 5'b0};
                mem_rdata    = pmem_rdata;
                mem_resp     = pmem_resp;
                if (pmem_resp) state_next = IDLE;
            end
            DRAIN: begin
                pmem_write   = 1'b1;
                pmem_address = {tags[head], 5'b0};
                pmem_wdata   = lines[head];
                if (pmem_resp) begin
                    state_next = IDLE;
                    count_next = count - 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            wb_empty <= 1'b1;
            rdata_q  <= '0;
        end else begin
            state    <= state_next;
            count    <= count_next;
            wb_empty <= (count_next == '0);
            if (state == IDLE) begin
                if (mem_read) begin
`ifdef WBUF_READ_FWD_EN
                    if (hit) rdata_q <= lines[hit_idx];
`endif
                end else if (mem_write) begin
                    if (hit) begin
                        lines[hit_idx] <= mem_wdata;
                    end else if (count != FULL) begin
                        tags[tail]  <= mem_address[31:5];
                        lines[tail] <= mem_wdata;
                        tail        <= tail + 1'b1;
                    end
                end
            end
            if (state == DRAIN && pmem_resp) head <= head + 1'b1;
        end
    end
endmodule

// File: tb/tb_cache_wb_buffer.sv
`timescale 1ns/1ps
// Bench for cache_wb_buffer: arbiter/memory model, queue-based reference, directed and random traffic.
module tb_cache_wb_buffer;
    logic         clk = 1'b0;
    logic         rst;
    logic [31:0]  mem_address;
    logic         mem_read, mem_write;
    logic [255:0] mem_wdata, mem_rdata;
    logic         mem_resp;
    logic [31:0]  pmem_address;
    logic         pmem_read, pmem_write;
    logic [255:0] pmem_wdata, pmem_rdata;
    logic         pmem_resp;
    logic         wb_empty;

    always #5 clk = ~clk;

    cache_wb_buffer #(.DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .mem_address(mem_address), .mem_read(mem_read), .mem_write(mem_write),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp),
        .pmem_address(pmem_address), .pmem_read(pmem_read), .pmem_write(pmem_write),
        .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp),
        .wb_empty(wb_empty)
    );

    typedef struct {logic [26:0] tag; logic [255:0] line;} ent_t;
    typedef struct {bit wr; logic [31:0] addr; logic [255:0] data; int exp_cycles;} vec_t;

    int checks = 0;
    int errors = 0;
    ent_t         mq[$];
    logic [255:0] shadow[logic [26:0]];
    logic [255:0] backing[logic [26:0]];
    logic [31:0]  drain_log[$];
    logic [255:0] drain_data[$];
    logic [31:0]  pread_log[$];
    int           resp_count = 0;
    bit           cur_wr;
    logic [31:0]  cur_addr;
    logic [255:0] cur_data, last_rdata;
    bit           last_resp_pmem;
    bit           rand_lat = 0, hold_resp = 0;
    int           lat = 0;
    int           cyc;
    vec_t         fill_tbl[5];

    task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic logic [255:0] defline(input logic [26:0] tag);
        logic [31:0] w;
        w = {tag, 5'b0} ^ 32'hC3A5_0F0F;
        return {8{w}};
    endfunction

    function automatic logic [255:0] mkline(input int k);
        logic [255:0] l;
        for (int i = 0; i < 8; i++) l[i*32 +: 32] = 32'hA000_0000 + 32'(k << 8) + 32'(i);
        return l;
    endfunction

    function automatic logic [255:0] randline();
        logic [255:0] l;
        for (int i = 0; i < 8; i++) l[i*32 +: 32] = $urandom();
        return l;
    endfunction

    function automatic int find_q(input logic [26:0] tag);
        for (int i = 0; i < mq.size(); i++) if (mq[i].tag == tag) return i;
        return -1;
    endfunction

    // Latest value written upstream wins, whether or not it has reached memory yet.
    function automatic logic [255:0] golden(input logic [26:0] tag);
        return shadow.exists(tag) ? shadow[tag] : defline(tag);
    endfunction

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic applyStimulus(input bit wr, input logic [31:0] addr, input logic [255:0] data,
                                 output int cycles);
        int start;
        cur_wr = wr; cur_addr = addr; cur_data = data;
        start = resp_count;
        mem_address = addr; mem_wdata = data; mem_read = !wr; mem_write = wr;
        cycles = 0;
        while (resp_count == start && cycles < 400) begin
            @(posedge clk); #1;
            cycles++;
        end
        mem_read = 1'b0; mem_write = 1'b0;
        if (resp_count == start) begin
            checks++; errors++;
            $display("[TB] FAIL req_timeout actual=no_resp expected=resp addr=%h", addr);
        end
    endtask

    task automatic wait_empty(input string name);
        int n = 0;
        while (!wb_empty && n < 600) begin @(posedge clk); #1; n++; end
        checkOutput(name, wb_empty, 1);
        idle(2);
    endtask

    // Arbiter: answers each request after a (possibly random) latency with a one-cycle pulse.
    initial begin
        pmem_resp = 1'b0; pmem_rdata = '0;
        forever begin
            @(posedge clk); #2;
            if (rst) begin
                pmem_resp = 1'b0; lat = 0;
            end else if (pmem_resp) begin
                pmem_resp = 1'b0;
            end else if ((pmem_read || pmem_write) && !hold_resp) begin
                if (lat > 0) lat--;
                else begin
                    if (pmem_write) backing[pmem_address[31:5]] = pmem_wdata;
                    else pmem_rdata = backing.exists(pmem_address[31:5]) ?
                                      backing[pmem_address[31:5]] : defline(pmem_address[31:5]);
                    pmem_resp = 1'b1;
                    lat = rand_lat ? int'($urandom_range(0, 3)) : 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (mem_read && mem_write) begin
                errors++;
                $display("[TB] FAIL protocol actual=read_and_write expected=one_request");
            end
            if (mem_resp) begin
                int idx;
                resp_count++;
                last_resp_pmem = pmem_read | pmem_write;
                if (cur_wr) begin
                    idx = find_q(cur_addr[31:5]);
                    if (idx >= 0) mq[idx].line = cur_data;
                    else mq.push_back('{cur_addr[31:5], cur_data});
                    shadow[cur_addr[31:5]] = cur_data;
                    checkOutput("wb_empty_after_write", wb_empty, 0);
                end else begin
                    last_rdata = mem_rdata;
                    checkOutput("read_data", mem_rdata, golden(cur_addr[31:5]));
                end
            end
            if (pmem_write && pmem_resp) begin
                if (mq.size() == 0) begin
                    checks++; errors++;
                    $display("[TB] FAIL drain_unexpected actual=%h expected=no_write", pmem_address);
                end else begin
                    checkOutput("drain_addr", pmem_address, {mq[0].tag, 5'b0});
                    checkOutput("drain_data", pmem_wdata, mq[0].line);
                    void'(mq.pop_front());
                end
                drain_log.push_back(pmem_address);
                drain_data.push_back(pmem_wdata);
            end
            if (pmem_read && pmem_resp) begin
                checkOutput("miss_addr", pmem_address, {cur_addr[31:5], 5'b0});
                checkOutput("miss_line_not_buffered", find_q(cur_addr[31:5]) >= 0, 0);
                pread_log.push_back(pmem_address);
            end
        end
    end

    initial begin
        #900000;
        $display("[TB] FAIL watchdog actual=running expected=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        for (int i = 0; i < 5; i++) begin
            fill_tbl[i].wr         = 1'b1;
            fill_tbl[i].addr       = 32'h100 + 32'(i) * 32'h20;
            fill_tbl[i].data       = mkline(i + 1);
            fill_tbl[i].exp_cycles = (i < 4) ? 2 : 4;
        end
        rst = 1'b1; mem_address = '0; mem_read = 1'b0; mem_write = 1'b0; mem_wdata = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        checkOutput("reset_wb_empty", wb_empty, 1);
        checkOutput("reset_mem_resp", mem_resp, 0);
        checkOutput("reset_pmem_read", pmem_read, 0);
        checkOutput("reset_pmem_write", pmem_write, 0);
        checkOutput("reset_pmem_address", pmem_address, 0);
        checkOutput("reset_mem_rdata", mem_rdata, 0);

        // Single write, then idle drain.
        applyStimulus(1, 32'h100, mkline(0), cyc);
        checkOutput("t1_latency", cyc, 2);
        checkOutput("t1_no_pmem_at_resp", last_resp_pmem, 0);
        wait_empty("t1_empty");
        checkOutput("t1_drain_count", drain_log.size(), 1);
        checkOutput("t1_drain_addr", drain_log[0], 32'h100);
        checkOutput("t1_drain_data", drain_data[0], mkline(0));

        // Fill to capacity, overflow forces the oldest out first.
        drain_log.delete(); drain_data.delete();
        for (int i = 0; i < 5; i++) begin
            applyStimulus(fill_tbl[i].wr, fill_tbl[i].addr, fill_tbl[i].data, cyc);
            checkOutput($sformatf("fill_latency_%0d", i), cyc, fill_tbl[i].exp_cycles);
        end
        wait_empty("fill_empty");
        checkOutput("fill_drain_count", drain_log.size(), 5);
        for (int i = 0; i < 5 && i < drain_log.size(); i++)
            checkOutput($sformatf("fill_drain_order_%0d", i), drain_log[i], fill_tbl[i].addr);

        // A read miss overtakes a pending write-back.
        drain_log.delete(); drain_data.delete(); pread_log.delete();
        applyStimulus(1, 32'h200, mkline(11), cyc);
        applyStimulus(0, 32'h300, '0, cyc);
        checkOutput("bypass_latency", cyc, 2);
        checkOutput("bypass_no_write_yet", drain_log.size(), 0);
        checkOutput("bypass_read_addr", pread_log.size() > 0 ? pread_log[0] : 32'hFFFF_FFFF, 32'h300);
        checkOutput("bypass_rdata", last_rdata, defline(27'(32'h300 >> 5)));
        wait_empty("bypass_empty");
        checkOutput("bypass_drain_addr", drain_log.size() > 0 ? drain_log[0] : 32'hFFFF_FFFF, 32'h200);

        // Two writes to the same line coalesce into one entry.
        drain_log.delete(); drain_data.delete();
        applyStimulus(1, 32'h200, mkline(11), cyc);
        applyStimulus(1, 32'h200, mkline(12), cyc);
        checkOutput("coalesce_latency", cyc, 2);
        wait_empty("coalesce_empty");
        checkOutput("coalesce_drain_count", drain_log.size(), 1);
        checkOutput("coalesce_drain_data", drain_data.size() > 0 ? drain_data[0] : '0, mkline(12));

        // Read hitting a buffered line.
        drain_log.delete(); drain_data.delete(); pread_log.delete();
        applyStimulus(1, 32'h240, mkline(13), cyc);
        applyStimulus(0, 32'h244, '0, cyc);
        checkOutput("hit_rdata", last_rdata, mkline(13));
`ifdef WBUF_READ_FWD_EN
        checkOutput("hit_fwd_latency", cyc, 2);
        checkOutput("hit_fwd_no_pread", pread_log.size(), 0);
        checkOutput("hit_fwd_no_drain", drain_log.size(), 0);
`else
        checkOutput("hit_nofwd_drain_count", drain_log.size(), 1);
        checkOutput("hit_nofwd_drain_addr", drain_log.size() > 0 ? drain_log[0] : 32'hFFFF_FFFF, 32'h240);
        checkOutput("hit_nofwd_pread_addr", pread_log.size() > 0 ? pread_log[0] : 32'hFFFF_FFFF, 32'h240);
`endif
        wait_empty("hit_empty");

        // Reset while a drain is stalled by the arbiter.
        hold_resp = 1'b1;
        applyStimulus(1, 32'h400, mkline(40), cyc);
        idle(1);
        checkOutput("rst_drain_active", pmem_write, 1);
        rst = 1'b1;
        idle(1);
        checkOutput("rst_pmem_write_drop", pmem_write, 0);
        checkOutput("rst_wb_empty", wb_empty, 1);
        rst = 1'b0; hold_resp = 1'b0;
        mq.delete(); shadow = backing; drain_log.delete(); drain_data.delete();
        idle(6);
        checkOutput("rst_no_drain", drain_log.size(), 0);
        checkOutput("rst_still_empty", wb_empty, 1);

        // Random traffic over a small address pool so hits, coalescing and wrap all occur.
        rand_lat = 1'b1;
        for (int n = 0; n < 300; n++) begin
            bit          wr;
            logic [31:0] a;
            idle($urandom_range(0, 3));
            wr = 1'($urandom_range(0, 1));
            a  = 32'h1000 + 32'($urandom_range(0, 7)) * 32'h20 + 32'($urandom_range(0, 31));
            applyStimulus(wr, a, randline(), cyc);
        end
        rand_lat = 1'b0;
        wait_empty("random_empty");
        checkOutput("random_model_empty", mq.size(), 0);
        foreach (shadow[t])
            checkOutput($sformatf("random_mem_%h", t), backing.exists(t) ? backing[t] : defline(t), shadow[t]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
